// File: rtl/full_half_pkg.sv
// Shared constants and types for the full_half ripple adder.
package full_half_pkg;

  localparam int unsigned FULL_HALF_WIDTH = 1;

  typedef struct packed {
    logic c;
    logic s;
  } sum_carry_t;

endpackage

// File: rtl/full_half_half_adder.sv
// One-bit half adder; two per bit form the full adder in full_half.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_half.sv
// WIDTH-bit ripple-carry adder built from per-bit half-adder pairs.
// Define FULL_HALF_OUT_REG_EN for registered outputs; otherwise purely combinational.
module full_half
  import full_half_pkg::*;
#(
  parameter int unsigned WIDTH = FULL_HALF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
);

  logic             carry [WIDTH+1];
  sum_carry_t       ha1   [WIDTH];
  sum_carry_t       ha2   [WIDTH];
  logic [WIDTH-1:0] sum_comb;
  logic             cout_comb;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha1 (
      .x (a[i]),
      .y (b[i]),
      .s (ha1[i].s),
      .c (ha1[i].c)
    );
    half_adder u_ha2 (
      .x (ha1[i].s),
      .y (carry[i]),
      .s (ha2[i].s),
      .c (ha2[i].c)
    );
    assign carry[i+1]  = ha1[i].c | ha2[i].c;
    assign sum_comb[i] = ha2[i].s;
  end

  assign cout_comb = carry[WIDTH];

`ifdef FULL_HALF_OUT_REG_EN
  logic             run_q;
  logic             capture;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // Single-flop release sync: first capture lands on the second edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign capture = in_valid & run_q;

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = capture;
    if (capture) begin
      sum_d  = sum_comb;
      cout_d = cout_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = out_valid_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst_n;
  assign Sum            = sum_comb;
  assign Cout           = cout_comb;
  assign out_valid      = in_valid;
`endif

endmodule

// File: tb/tb_full_half.sv
// Directed and randomised checks of full_half at WIDTH 1, 4 and 8, in either output mode.
module tb_full_half;

  logic       clk;
  logic       rst_n;
  logic       cin;
  logic       in_valid;
  logic       a1, b1, s1, c1, ov1;
  logic [3:0] a4, b4, s4;
  logic       c4, ov4;
  logic [7:0] a8, b8, s8;
  logic       c8, ov8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  full_half #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .Cin(cin), .in_valid(in_valid),
    .Sum(s1), .Cout(c1), .out_valid(ov1)
  );
  full_half #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .Cin(cin), .in_valid(in_valid),
    .Sum(s4), .Cout(c4), .out_valid(ov4)
  );
  full_half #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .Cin(cin), .in_valid(in_valid),
    .Sum(s8), .Cout(c8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic v);
    @(negedge clk);
    a1 = av[0]; b1 = bv[0];
    a4 = av[3:0]; b4 = bv[3:0];
    a8 = av; b8 = bv;
    cin = c; in_valid = v;
  endtask

  task automatic settle();
`ifdef FULL_HALF_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sum_tab;
    logic [7:0] cout_tab;
    logic [2:0] idx;
    logic [7:0] av, bv;
    logic       cv, vv;
    logic [8:0] full;
    logic [8:0] exp8;
    logic       exp_ov;
    logic       exp_s, exp_c, exp_v;

    sum_tab  = 8'b1001_0110;
    cout_tab = 8'b1110_1000;

    rst_n = 1'b0; cin = 1'b0; in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #1;
    chk("reset_sum8",  64'(s8),  64'd0);
    chk("reset_cout8", 64'(c8),  64'd0);
    chk("reset_ov8",   64'(ov8), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);

    // Exhaustive WIDTH=1 sweep of {a,b,Cin}
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      drive({7'd0, idx[2]}, {7'd0, idx[1]}, idx[0], 1'b1);
      settle();
      chk($sformatf("sweep_sum_%0d", i),  64'(s1),  64'(sum_tab[idx]));
      chk($sformatf("sweep_cout_%0d", i), 64'(c1),  64'(cout_tab[idx]));
      chk($sformatf("sweep_ov_%0d", i),   64'(ov1), 64'd1);
    end

    // Single valid cycle followed by an idle cycle
    drive(8'd1, 8'd1, 1'b1, 1'b1);
    settle();
    chk("one_shot_sum",  64'(s1),  64'd1);
    chk("one_shot_cout", 64'(c1),  64'd1);
    chk("one_shot_ov",   64'(ov1), 64'd1);
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    settle();
`ifdef FULL_HALF_OUT_REG_EN
    exp_s = 1'b1; exp_c = 1'b1;
`else
    exp_s = 1'b0; exp_c = 1'b0;
`endif
    chk("idle_ov",   64'(ov1), 64'd0);
    chk("idle_sum",  64'(s1),  64'(exp_s));
    chk("idle_cout", 64'(c1),  64'(exp_c));

    // WIDTH=4 full ripple and wrap-around
    drive(8'h0F, 8'h01, 1'b0, 1'b1);
    settle();
    chk("ripple_sum4",  64'(s4), 64'h0);
    chk("ripple_cout4", 64'(c4), 64'd1);
    drive(8'h0F, 8'h0F, 1'b1, 1'b1);
    settle();
    chk("wrap_sum4",  64'(s4), 64'hF);
    chk("wrap_cout4", 64'(c4), 64'd1);
    drive(8'hFF, 8'hFF, 1'b1, 1'b1);
    settle();
    chk("wrap_sum8",  64'(s8), 64'hFF);
    chk("wrap_cout8", 64'(c8), 64'd1);

    // Reset asserted mid-cycle while in_valid is high
    drive(8'd1, 8'd1, 1'b1, 1'b1);
    settle();
    chk("pre_rst_ov", 64'(ov1), 64'd1);
    drive(8'd1, 8'd1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
`ifdef FULL_HALF_OUT_REG_EN
    exp_s = 1'b0; exp_c = 1'b0; exp_v = 1'b0;
`else
    exp_s = 1'b1; exp_c = 1'b1; exp_v = 1'b1;
`endif
    chk("rst_async_sum",  64'(s1),  64'(exp_s));
    chk("rst_async_cout", 64'(c1),  64'(exp_c));
    chk("rst_async_ov",   64'(ov1), 64'(exp_v));
    @(posedge clk);
    #1;
    chk("rst_edge_ov", 64'(ov1), 64'(exp_v));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sync_edge_ov", 64'(ov1), 64'(exp_v));
    @(posedge clk);
    #1;
    chk("rst_first_cap_ov",  64'(ov1), 64'd1);
    chk("rst_first_cap_sum", 64'(s1),  64'd1);

    // WIDTH=8 random vectors with intermittent in_valid
    exp8   = '0;
    exp_ov = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      cv = 1'($urandom);
      vv = (k == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(av, bv, cv, vv);
      full = 9'(av) + 9'(bv) + 9'(cv);
`ifdef FULL_HALF_OUT_REG_EN
      if (vv) exp8 = full;
`else
      exp8 = full;
`endif
      exp_ov = vv;
      settle();
      chk($sformatf("rand_sum_%0d", k), 64'({c8, s8}), 64'(exp8));
      chk($sformatf("rand_ov_%0d", k),  64'(ov8),      64'(exp_ov));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
